// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the divider arbiter.
package div_arbiter_pkg;

  localparam int W = 8;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } div_state_t;

  localparam logic [W-1:0] DZ_QUOT = '1;

  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Requester, response and divider signals of the divider arbiter.
interface div_arbiter_if #(parameter int W = 8);

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_q;
  logic [W-1:0] rsp_r;
  logic         rsp_dz;
  logic         rsp_err;

  logic         div_start;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic         div_done;
  logic [W-1:0] div_q;
  logic [W-1:0] div_r;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  rsp_ready, div_done, div_q, div_r,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_err,
    output div_start, div_a, div_b
  );

  // Requesters, consumer and divider side.
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output rsp_ready, div_done, div_q, div_r,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_err,
    input  div_start, div_a, div_b
  );

endinterface

// File: rtl/div_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |valid;
    gnt_id    = 1'b0;
    if (valid == 2'b11) begin
      gnt_id = ~last_grant;
    end else begin
      gnt_id = valid[1];
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one multi-cycle divider between two requesters; single outstanding op,
// local divide-by-zero handling and a watchdog for a hung divider.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic          clk,
  input logic          rst_n,
  div_arbiter_if.slave bus
);

  localparam int WDW = wd_width(TIMEOUT);

  div_state_t     state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic [W-1:0]   div_a_q, div_a_d;
  logic [W-1:0]   div_b_q, div_b_d;
  logic           rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_quot_q, rsp_quot_d;
  logic [W-1:0]   rsp_rem_q, rsp_rem_d;
  logic           rsp_dz_q, rsp_dz_d;
  logic           rsp_err_q, rsp_err_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [WDW-1:0] wd_nx;

  logic           gnt_valid;
  logic           gnt_id;
  logic           accept;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;

  rr_arb2 u_arb (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  assign accept = (state_q == IDLE) && gnt_valid;
  assign sel_a  = gnt_id ? bus.req1_a : bus.req0_a;
  assign sel_b  = gnt_id ? bus.req1_b : bus.req0_b;
  assign wd_nx  = wd_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_quot_d   = rsp_quot_q;
    rsp_rem_d    = rsp_rem_q;
    rsp_dz_d     = rsp_dz_q;
    rsp_err_d    = rsp_err_q;
    wd_d         = wd_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          div_a_d      = sel_a;
          div_b_d      = sel_b;
          rsp_id_d     = gnt_id;
          last_grant_d = gnt_id;
          if (sel_b == '0) begin
            // Divide-by-zero answers immediately without touching the divider.
            rsp_quot_d = DZ_QUOT;
            rsp_rem_d  = sel_a;
            rsp_dz_d   = 1'b1;
            rsp_err_d  = 1'b0;
            state_d    = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_nx;
        // A done arriving on the timeout cycle still delivers the real result.
        if (bus.div_done) begin
          rsp_quot_d = bus.div_q;
          rsp_rem_d  = bus.div_r;
          rsp_dz_d   = 1'b0;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (wd_nx == WDW'(TIMEOUT)) begin
          rsp_quot_d = '0;
          rsp_rem_d  = '0;
          rsp_dz_d   = 1'b0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      div_a_q      <= '0;
      div_b_q      <= '0;
      rsp_id_q     <= 1'b0;
      rsp_quot_q   <= '0;
      rsp_rem_q    <= '0;
      rsp_dz_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_quot_q   <= rsp_quot_d;
      rsp_rem_q    <= rsp_rem_d;
      rsp_dz_q     <= rsp_dz_d;
      rsp_err_q    <= rsp_err_d;
      wd_q         <= wd_d;
    end
  end

  assign bus.req0_ready = accept && !gnt_id;
  assign bus.req1_ready = accept && gnt_id;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_q      = rsp_quot_q;
  assign bus.rsp_r      = rsp_rem_q;
  assign bus.rsp_dz     = rsp_dz_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.div_start  = (state_q == ISSUE);
  assign bus.div_a      = div_a_q;
  assign bus.div_b      = div_b_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: divider model, response scoreboard, latency and reset checks.
module tb_div_arbiter;
  import div_arbiter_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_arbiter_if #(.W(W)) bus ();

  div_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic         id;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         err;
  } exp_t;

  exp_t sb[$];
  bit   hang = 1'b0;
  int   hs_cyc = 0;
  int   start_cyc = 0;
  int   rspv_cyc = 0;
  int   n_start = 0;
  logic rspv_prev = 1'b0;

  int           dcnt = 0;
  logic [W-1:0] ma = '0;
  logic [W-1:0] mb = 8'd1;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.id = id;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.err = 1'b0;
    end else if (hang) begin
      e.q = '0; e.r = '0; e.dz = 1'b0; e.err = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.err = 1'b0;
    end
    return e;
  endfunction

  // Divider model: done pulses 9 cycles after start unless hung.
  always @(negedge clk) begin
    bus.div_done = 1'b0;
    if (bus.div_start) begin
      n_start++;
      start_cyc = cyc;
      dcnt = 9;
      ma = bus.div_a;
      mb = bus.div_b;
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0 && !hang) begin
        bus.div_done = 1'b1;
        bus.div_q = ma / mb;
        bus.div_r = ma % mb;
      end
    end
  end

  // Handshake capture and response scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.req0_ready && bus.req1_ready) chk("both_ready", 1, 0);
      if (bus.req0_valid && bus.req0_ready) begin
        sb.push_back(model(1'b0, bus.req0_a, bus.req0_b));
        hs_cyc = cyc;
      end
      if (bus.req1_valid && bus.req1_ready) begin
        sb.push_back(model(1'b1, bus.req1_a, bus.req1_b));
        hs_cyc = cyc;
      end
      if (bus.rsp_valid && !rspv_prev) rspv_cyc = cyc;
      rspv_prev = bus.rsp_valid;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          chk("rsp_q", 32'(bus.rsp_q), 32'(e.q));
          chk("rsp_r", 32'(bus.rsp_r), 32'(e.r));
          chk("rsp_dz", 32'(bus.rsp_dz), 32'(e.dz));
          chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        end
      end
    end else begin
      rspv_prev = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input bit id, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = id ? bus.req1_ready : bus.req0_ready;
    end
    @(posedge clk);
    #1;
    if (id) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
    chk(tag, 32'(got), 1);
  endtask

  task automatic send(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    if (id) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end
    wait_accept(id, tag);
  endtask

  task automatic pair(input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic [W-1:0] a1, input logic [W-1:0] b1,
                      input int exp_first, input string tag);
    bit d0 = 1'b0;
    bit d1 = 1'b0;
    int first = -1;
    bus.req0_a = a0; bus.req0_b = b0; bus.req0_valid = 1'b1;
    bus.req1_a = a1; bus.req1_b = b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 300 && !(d0 && d1); i++) begin
      @(negedge clk);
      if (bus.req0_ready) begin
        if (first < 0) first = 0;
        d0 = 1'b1;
      end
      if (bus.req1_ready) begin
        if (first < 0) first = 1;
        d1 = 1'b1;
      end
      @(posedge clk);
      #1;
      if (d0) bus.req0_valid = 1'b0;
      if (d1) bus.req1_valid = 1'b0;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk({tag, "_first"}, 32'(first), 32'(exp_first));
    chk({tag, "_both"}, 32'({d0, d1}), 32'b11);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    chk(tag, 32'(sb.size()), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_rsp_bits"}, 32'({bus.rsp_id, bus.rsp_dz, bus.rsp_err, bus.rsp_q, bus.rsp_r}), 0);
    chk({tag, "_div"}, 32'({bus.div_start, bus.div_a, bus.div_b}), 0);
    chk({tag, "_ready"}, 32'({bus.req0_ready, bus.req1_ready}), 0);
  endtask

  initial begin
    int n0;
    int seen;
    logic [W-1:0] snap_q, snap_r;
    logic snap_id;

    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b1;

    step(3);
    check_zero_outputs("reset_low");
    rst_n = 1'b1;
    step(1);
    @(negedge clk);
    check_zero_outputs("reset_idle");
    step(1);

    // Simultaneous pair from reset: requester 0 wins the first tie.
    pair(8'd200, 8'd9, 8'd50, 8'd5, 0, "pair1");
    wait_drain("pair1_drain");

    // Single op with latency measurement.
    n0 = n_start;
    send(1'b0, 8'd100, 8'd7, "acc_100_7");
    wait_drain("op1_drain");
    chk("op1_starts", 32'(n_start - n0), 1);
    chk("op1_start_lat", 32'(start_cyc - hs_cyc), 1);
    chk("op1_rsp_lat", 32'(rspv_cyc - hs_cyc), 11);

    // Requester 0 was granted last, so requester 1 wins this tie.
    pair(8'd80, 8'd3, 8'd255, 8'd16, 1, "pair2");
    wait_drain("pair2_drain");

    // Divide by zero never reaches the divider.
    n0 = n_start;
    send(1'b1, 8'd37, 8'd0, "acc_dz");
    wait_drain("dz_drain");
    chk("dz_no_start", 32'(n_start - n0), 0);
    chk("dz_rsp_lat", 32'(rspv_cyc - hs_cyc), 1);

    // Hung divider: watchdog answers with err after TIMEOUT wait cycles.
    hang = 1'b1;
    send(1'b0, 8'd50, 8'd3, "acc_hang");
    wait_drain("hang_drain");
    chk("hang_rsp_lat", 32'(rspv_cyc - hs_cyc), TO + 2);
    hang = 1'b0;
    send(1'b0, 8'd13, 8'd4, "acc_after_hang");
    wait_drain("after_hang_drain");

    // Backpressure: response held, no new accept while stalled.
    bus.rsp_ready = 1'b0;
    send(1'b1, 8'd90, 8'd4, "acc_bp");
    bus.req0_a = 8'd9; bus.req0_b = 8'd2; bus.req0_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    chk("bp_rsp_valid", 32'(seen), 1);
    snap_q = bus.rsp_q; snap_r = bus.rsp_r; snap_id = bus.rsp_id;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus.rsp_valid), 1);
      chk("bp_hold_data", 32'({bus.rsp_id, bus.rsp_q, bus.rsp_r}), 32'({snap_id, snap_q, snap_r}));
      chk("bp_no_ready", 32'({bus.req0_ready, bus.req1_ready}), 0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    wait_accept(1'b0, "acc_after_bp");
    wait_drain("bp_drain");

    // Reset during WAIT aborts the op; the late done is ignored.
    send(1'b0, 8'd120, 8'd11, "acc_abort");
    step(4);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    sb.delete();
    step(2);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    chk("abort_no_rsp", 32'(seen), 0);
    step(1);
    send(1'b1, 8'd99, 8'd10, "acc_post_reset");
    wait_drain("post_reset_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
